// File: rtl/memory_access_stage_pkg.sv
// Shared pipeline types for the memory-access stage: size/state encodings, writeback payload,
// and the lane helpers used when a load/store is launched.
package memory_access_stage_pkg;

    localparam int unsigned ADDR_WIDTH    = 32;
    localparam int unsigned DATA_WIDTH    = 32;
    localparam int unsigned BE_WIDTH      = DATA_WIDTH / 8;
    localparam int unsigned REG_IDX_WIDTH = 5;

    typedef enum logic [1:0] {
        SIZE_BYTE    = 2'b00,
        SIZE_HALF    = 2'b01,
        SIZE_WORD    = 2'b10,
        SIZE_ILLEGAL = 2'b11
    } MemAccessSize;

    typedef enum logic {
        STATE_IDLE   = 1'b0,
        STATE_ACCESS = 1'b1
    } MemAccessState;

    typedef struct packed {
        logic                     valid;
        logic [REG_IDX_WIDTH-1:0] rd;
        logic                     rdWe;
        logic [DATA_WIDTH-1:0]    data;
    } WriteBackStagePipeReg;

    function automatic logic isMisaligned(input logic [1:0] size, input logic [1:0] offset);
        case (size)
            SIZE_BYTE: isMisaligned = 1'b0;
            SIZE_HALF: isMisaligned = offset[0];
            default:   isMisaligned = (offset != 2'b00);
        endcase
    endfunction

    function automatic logic [BE_WIDTH-1:0] byteEnables(input logic [1:0] size, input logic [1:0] offset);
        case (size)
            SIZE_BYTE: byteEnables = BE_WIDTH'(4'b0001) << offset;
            SIZE_HALF: byteEnables = BE_WIDTH'(4'b0011) << offset;
            default:   byteEnables = '1;
        endcase
    endfunction

    // Narrow stores replicate across every lane so the enabled lane always carries the operand.
    function automatic logic [DATA_WIDTH-1:0] replicateStore(input logic [1:0] size,
                                                             input logic [DATA_WIDTH-1:0] data);
        case (size)
            SIZE_BYTE: replicateStore = {4{data[7:0]}};
            SIZE_HALF: replicateStore = {2{data[15:0]}};
            default:   replicateStore = data;
        endcase
    endfunction

endpackage

// File: rtl/memory_access_stage_if.sv
// Data-memory request/acknowledge bus between the memory-access stage and data memory.
interface memory_access_stage_if;
    import memory_access_stage_pkg::*;

    logic                  dmem_req;
    logic                  dmem_we;
    logic [ADDR_WIDTH-1:0] dmem_addr;
    logic [BE_WIDTH-1:0]   dmem_be;
    logic [DATA_WIDTH-1:0] dmem_wdata;
    logic                  dmem_ack;
    logic [DATA_WIDTH-1:0] dmem_rdata;

    modport master (
        output dmem_req, dmem_we, dmem_addr, dmem_be, dmem_wdata,
        input  dmem_ack, dmem_rdata
    );

    modport slave (
        input  dmem_req, dmem_we, dmem_addr, dmem_be, dmem_wdata,
        output dmem_ack, dmem_rdata
    );

endinterface

// File: rtl/mem_load_aligner.sv
// Combinational load formatter: selects the addressed byte/half/word of the raw read word
// and sign- or zero-extends it to the datapath width.
module mem_load_aligner
    import memory_access_stage_pkg::*;
(
    input  logic [DATA_WIDTH-1:0] rdata,
    input  logic [1:0]            offset,
    input  logic [1:0]            size,
    input  logic                  isUnsigned,
    output logic [DATA_WIDTH-1:0] loadData_c
);

    logic [DATA_WIDTH-1:0] shifted;

    always_comb begin
        shifted    = rdata >> {offset, 3'b000};
        loadData_c = shifted;
        case (size)
            SIZE_BYTE: loadData_c = {{(DATA_WIDTH-8){shifted[7] & ~isUnsigned}}, shifted[7:0]};
            SIZE_HALF: loadData_c = {{(DATA_WIDTH-16){shifted[15] & ~isUnsigned}}, shifted[15:0]};
            default:   loadData_c = shifted;
        endcase
    end

endmodule

// File: rtl/memory_access_stage.sv
// Memory-access pipeline stage: launches loads/stores over the dmem req/ack bus, stalls upstream
// while a transaction is outstanding, and registers the writeback pipe register.
module memory_access_stage
    import memory_access_stage_pkg::*;
(
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     ex_valid,
    input  logic                     ex_is_load,
    input  logic                     ex_is_store,
    input  logic [1:0]               ex_size,
    input  logic                     ex_unsigned,
    input  logic [DATA_WIDTH-1:0]    ex_result,
    input  logic [DATA_WIDTH-1:0]    ex_store_data,
    input  logic [REG_IDX_WIDTH-1:0] ex_rd,
    input  logic                     ex_rd_we,
    input  logic                     flush,
    memory_access_stage_if.master    dmem,
    output logic                     stall,
    output logic                     wb_valid,
    output logic [REG_IDX_WIDTH-1:0] wb_rd,
    output logic                     wb_rd_we,
    output logic [DATA_WIDTH-1:0]    wb_data,
    output logic                     misalign,
    output logic [ADDR_WIDTH-1:0]    misalign_addr
);

    localparam logic [0:0] IDLE   = STATE_IDLE;
    localparam logic [0:0] ACCESS = STATE_ACCESS;

    logic [0:0] state, stateNext;

    logic                     accLoad, accUnsigned, accRdWe;
    logic [1:0]               accSize, accOff;
    logic [REG_IDX_WIDTH-1:0] accRd;
    logic                     dmemWe;
    logic [ADDR_WIDTH-1:0]    dmemAddr;
    logic [BE_WIDTH-1:0]      dmemBe;
    logic [DATA_WIDTH-1:0]    dmemWdata;

    WriteBackStagePipeReg wbReg, wbNext, pendWb, pendNext, newWb, doneWb;
    logic                 accept, isMem, memDone, latchEn, misalignNext;
    logic [ADDR_WIDTH-1:0] exAddr;
    logic [DATA_WIDTH-1:0] loadData_c;

    assign exAddr = ADDR_WIDTH'(ex_result);
    assign stall  = (state == ACCESS) && !dmem.dmem_ack;

    mem_load_aligner u_aligner (
        .rdata      (dmem.dmem_rdata),
        .offset     (accOff),
        .size       (accSize),
        .isUnsigned (accUnsigned),
        .loadData_c (loadData_c)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= IDLE;
        else      state <= stateNext;
    end

    // A non-mem op accepted on a completing edge is parked in pendWb and written back one cycle
    // behind the memory op; writebacks therefore always leave in program order.
    always_comb begin
        stateNext    = state;
        latchEn      = 1'b0;
        misalignNext = 1'b0;
        wbNext       = '0;
        pendNext     = '0;
        isMem        = ex_is_load | ex_is_store;
        accept       = ex_valid && !flush && !stall;
        memDone      = (state == ACCESS) && dmem.dmem_ack;
        newWb        = '{valid: 1'b1, rd: ex_rd, rdWe: ex_rd_we, data: ex_result};
        doneWb       = '{valid: 1'b1, rd: accRd, rdWe: accLoad & accRdWe,
                         data: accLoad ? loadData_c : '0};

        if (memDone) stateNext = IDLE;
        if (accept && isMem) begin
            if (isMisaligned(ex_size, exAddr[1:0])) begin
                misalignNext = 1'b1;
            end else begin
                latchEn   = 1'b1;
                stateNext = ACCESS;
            end
        end

        if (pendWb.valid)            wbNext = pendWb;
        else if (memDone)            wbNext = doneWb;
        else if (accept && !isMem)   wbNext = newWb;

        if ((pendWb.valid || memDone) && accept && !isMem) pendNext = newWb;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wbReg         <= '0;
            pendWb        <= '0;
            misalign      <= 1'b0;
            misalign_addr <= '0;
            accLoad       <= 1'b0;
            accUnsigned   <= 1'b0;
            accRdWe       <= 1'b0;
            accSize       <= 2'b00;
            accOff        <= 2'b00;
            accRd         <= '0;
            dmemWe        <= 1'b0;
            dmemAddr      <= '0;
            dmemBe        <= '0;
            dmemWdata     <= '0;
        end else begin
            wbReg         <= wbNext;
            pendWb        <= pendNext;
            misalign      <= misalignNext;
            misalign_addr <= misalignNext ? exAddr : '0;
            if (latchEn) begin
                accLoad     <= ex_is_load;
                accUnsigned <= ex_unsigned;
                accRdWe     <= ex_rd_we;
                accSize     <= ex_size;
                accOff      <= exAddr[1:0];
                accRd       <= ex_rd;
                dmemWe      <= ex_is_store;
                dmemAddr    <= {exAddr[ADDR_WIDTH-1:2], 2'b00};
                dmemBe      <= byteEnables(ex_size, exAddr[1:0]);
                dmemWdata   <= replicateStore(ex_size, ex_store_data);
            end
        end
    end

    assign dmem.dmem_req   = (state == ACCESS);
    assign dmem.dmem_we    = dmemWe;
    assign dmem.dmem_addr  = dmemAddr;
    assign dmem.dmem_be    = dmemBe;
    assign dmem.dmem_wdata = dmemWdata;

    assign wb_valid = wbReg.valid;
    assign wb_rd    = wbReg.rd;
    assign wb_rd_we = wbReg.rdWe;
    assign wb_data  = wbReg.data;

endmodule
